// File: rtl/arrow_judge_pkg.sv
// Shared definitions for the arrow judge: code base, rest code, FSM states,
// arrow decoding and direction-to-button mapping.
package arrow_judge_pkg;

    localparam int          ARROW_BASE_DEF = 10;
    localparam int          NUM_ARROWS     = 5;
    localparam logic [2:0]  REST           = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Codes base..base+3 are directions 0..3 and base+4 is rest; anything else also means rest.
    function automatic logic [2:0] decode_arrow(input logic [3:0] code, input int base);
        int d;
        d = int'(code) - base;
        if (d >= 0 && d < NUM_ARROWS) begin
            return d[2:0];
        end
        return REST;
    endfunction

    // Button bits are up/down/left/right for directions 0/1/2/3; rest has no button.
    function automatic logic [3:0] dir_to_btn(input logic [2:0] dir);
        logic [3:0] mask;
        case (dir)
            3'd0:    mask = 4'b0001;
            3'd1:    mask = 4'b0010;
            3'd2:    mask = 4'b0100;
            3'd3:    mask = 4'b1000;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/arrow_judge_btn_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector, one lane per button bit.
module btn_edge_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/arrow_judge.sv
// Arrow judge: scrolls decoded arrows through a DEPTH-slot queue on each beat and judges
// synchronised button presses against slot 0. Define ARROW_JUDGE_COMBO_EN for the combo counter.
module arrow_judge
    import arrow_judge_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ARROW_BASE = ARROW_BASE_DEF,
    parameter int SCORE_W    = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 beat,
    input  logic                 play,
    input  logic [3:0]           arrow_in,
    input  logic [3:0]           btn,
    output logic [3*DEPTH-1:0]   queue_o,
    output logic                 hit,
    output logic                 miss,
    output logic [SCORE_W-1:0]   score,
    output logic [7:0]           combo
);

    logic [3:0]              btn_rise;
    logic                    press;
    logic                    correct;
    logic [DEPTH-1:0][2:0]   queue_q;
    logic [DEPTH-1:0][2:0]   queue_d;
    state_e                  state_q;
    state_e                  next_win;
    logic                    hit_d;
    logic                    miss_d;
    logic                    hit_q;
    logic                    miss_q;
    logic [SCORE_W-1:0]      score_q;

    btn_edge_sync #(.WIDTH(4)) u_btn_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn),
        .rise_o (btn_rise)
    );

    assign press   = |btn_rise;
    assign correct = (btn_rise == dir_to_btn(queue_q[0]));

    // Holding play low keeps the queue at rest, which also performs the flush on the falling edge.
    always_comb begin
        // NOTE: a default assignment first keeps always_comb free of inferred latches.
        queue_d = queue_q;
        if (!play) begin
            queue_d = {DEPTH{REST}};
        end else if (beat) begin
            for (int k = 0; k < DEPTH - 1; k++) begin
                queue_d[k] = queue_q[k + 1];
            end
            queue_d[DEPTH-1] = decode_arrow(arrow_in, ARROW_BASE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            queue_q <= {DEPTH{REST}};
        end else begin
            queue_q <= queue_d;
        end
    end

    // A press on the beat cycle is judged against the outgoing target, suppressing expiry.
    always_comb begin
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        next_win = (queue_d[0] == REST) ? ST_DONE : ST_WAIT;
        if (play && state_q == ST_WAIT) begin
            if (press) begin
                hit_d  = correct;
                miss_d = !correct;
            end else if (beat) begin
                miss_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            score_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
            if (hit_d && score_q != '1) begin
                score_q <= score_q + SCORE_W'(1);
            end
            if (!play) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= next_win;
                    ST_WAIT: begin
                        if (beat) begin
                            state_q <= next_win;
                        end else if (press) begin
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (beat) begin
                            state_q <= next_win;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef ARROW_JUDGE_COMBO_EN
    logic [7:0] combo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            combo_q <= 8'd0;
        end else if (!play || miss_d) begin
            combo_q <= 8'd0;
        end else if (hit_d && combo_q != 8'hFF) begin
            combo_q <= combo_q + 8'd1;
        end
    end

    assign combo = combo_q;
`else
    assign combo = 8'd0;
`endif

    assign queue_o = queue_q;
    assign hit     = hit_q;
    assign miss    = miss_q;
    assign score   = score_q;

endmodule

// File: tb/tb_arrow_judge.sv
// Scoreboard bench for arrow_judge: stimulus queues expected hit/miss events, a monitor checks pulses.
module tb_arrow_judge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        beat;
    logic        play;
    logic [3:0]  arrow_in;
    logic [3:0]  btn;
    logic [11:0] queue_o;
    logic        hit;
    logic        miss;
    logic [9:0]  score;
    logic [7:0]  combo;

    typedef struct {
        bit is_hit;
        int cyc;
        int score;
        int combo;
    } evt_t;

    evt_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    arrow_judge dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .beat     (beat),
        .play     (play),
        .arrow_in (arrow_in),
        .btn      (btn),
        .queue_o  (queue_o),
        .hit      (hit),
        .miss     (miss),
        .score    (score),
        .combo    (combo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int cexp(input int v);
`ifdef ARROW_JUDGE_COMBO_EN
        return (v > 255) ? 255 : v;
`else
        return (v > 255) ? 0 : 0;
`endif
    endfunction

    function automatic void expect_evt(input bit is_hit, input int at, input int sc, input int cb);
        evt_t e;
        e.is_hit = is_hit;
        e.cyc    = at;
        e.score  = sc;
        e.combo  = cexp(cb);
        exp_q.push_back(e);
    endfunction

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (hit || miss)) begin
            evt_t e;
            check("hit_miss_exclusive", longint'(hit & miss), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", longint'({hit, miss}), 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_hit", longint'(hit), longint'(e.is_hit));
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_score", longint'(score), e.score);
                check("pulse_combo", longint'(combo), e.combo);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_beat(input logic [3:0] code);
        beat     = 1'b1;
        arrow_in = code;
        tick();
        beat     = 1'b0;
    endtask

    task automatic press(input logic [3:0] bits);
        btn = bits;
        tick();
        tick();
        btn = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; beat = 1'b0; play = 1'b0; arrow_in = 4'd0; btn = 4'd0;
        repeat (3) tick();
        rst_n = 1'b1;
        play  = 1'b1;
        tick();
        check("reset_queue", queue_o, 12'h924);
        check("reset_score", score, 0);
        check("reset_hit", hit, 0);
        check("reset_miss", miss, 0);
        check("reset_combo", combo, 0);

        // Fill the queue: slot0..3 = directions 0..3.
        do_beat(4'd10); do_beat(4'd11); do_beat(4'd12); do_beat(4'd13);
        check("queue_filled", queue_o, 12'h688);
        expect_evt(1, cyc + 3, 1, 1);
        press(4'b0001);
        press(4'b0001);                       // second press in the same window is ignored
        check("score_after_first_hit", score, 1);

        do_beat(4'd10);                       // target 1
        expect_evt(1, cyc + 3, 2, 2);
        press(4'b0010);
        do_beat(4'd9);                        // target 2, left unpressed
        expect_evt(0, cyc + 1, 2, 0);
        do_beat(4'd15);                       // expiry miss lands on this beat
        check("queue_after_expiry", queue_o, 12'h903);
        expect_evt(0, cyc + 3, 2, 0);
        press(4'b0100);                       // wrong button on target 3
        do_beat(4'd12);                       // target 0
        expect_evt(0, cyc + 3, 2, 0);
        press(4'b0011);                       // two edges incl. target counts as wrong
        do_beat(4'd13);                       // target rest
        press(4'b0001);                       // presses on rest do nothing
        do_beat(4'd0);
        do_beat(4'd14);                       // target 2
        check("queue_before_coincide", queue_o, 12'h91A);
        check("score_before_coincide", score, 2);

        // Correct edge reaches the judge on the same cycle as the beat.
        expect_evt(1, cyc + 3, 3, 1);
        btn = 4'b0100;
        tick(); tick();
        beat = 1'b1; arrow_in = 4'd11;
        tick();
        beat = 1'b0; btn = 4'b0000;
        tick(); tick();
        expect_evt(1, cyc + 3, 4, 2);
        press(4'b1000);                       // new target 3 was loaded by the shared beat

        do_beat(4'd10); do_beat(4'd10); do_beat(4'd10);
        check("queue_mid_window", queue_o, 12'h001);
        play = 1'b0;                          // leave mid-WAIT: flush, no pulse
        tick(); tick();
        check("queue_flushed", queue_o, 12'h924);
        check("combo_flushed", combo, 0);
        check("score_kept", score, 4);
        play = 1'b1;
        tick();
        do_beat(4'd13); do_beat(4'd13); do_beat(4'd13); do_beat(4'd13);
        check("queue_all_right", queue_o, 12'h6DB);
        rst_n = 1'b0;
        #1;
        check("async_reset_queue", queue_o, 12'h924);
        check("async_reset_score", score, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Saturation: 1025 hits on a stream of direction-0 arrows.
        do_beat(4'd10); do_beat(4'd10); do_beat(4'd10); do_beat(4'd10);
        for (int i = 1; i <= 1025; i++) begin
            expect_evt(1, cyc + 3, (i > 1023) ? 1023 : i, i);
            press(4'b0001);
            do_beat(4'd10);
        end
        check("score_saturated", score, 1023);
        play = 1'b0;
        repeat (4) tick();
        check("pending_events", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
